// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-requester arbiter.
package arb_pkg;
   localparam int NREQ = 8;
   localparam int IDW  = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;
endpackage

// File: rtl/rr_select8.sv
// Combinational 8-to-3 priority select with optional rotation; the requester
// just below base wins first, base itself is searched last.
module rr_select8
   import arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  base,
   input  logic            mode,
   output logic            sel_valid,
   output logic [IDW-1:0]  sel_id
);

   logic [IDW-1:0]  rot_base;
   logic [NREQ-1:0] req_rot;
   logic [IDW-1:0]  pos;

   // fixed priority is the rotation with base 0
   assign rot_base = mode ? base : '0;

   always_comb begin
      req_rot = '0;
      for (int k = 0; k < NREQ; k++) begin
         req_rot[k] = req[IDW'(k + int'(rot_base))];
      end
   end

   always_comb begin
      pos = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (req_rot[k]) pos = IDW'(k);
      end
   end

   assign sel_valid = |req;
   assign sel_id    = pos + rot_base;

endmodule

// File: rtl/req_arbiter8.sv
// Sequential 8-way arbiter: registered one-hot grant, round-robin or fixed
// priority, hold-time limit with a one-cycle preempt pulse.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no owner; arbitrate req when en = 1, outputs gnt = 0
//   ST_GRANT | owner gnt_id holds the resource until release/limit/abort
module req_arbiter8
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 15,
   parameter int HOLD_W   = 4
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [NREQ-1:0]  req,
   input  logic             done,
   output logic [NREQ-1:0]  gnt,
   output logic [IDW-1:0]   gnt_id,
   output logic             gnt_valid,
   output logic             preempt
);

   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (HOLD_MAX == 0) ? '0 : HOLD_W'(HOLD_MAX - 1);

   state_t              state, state_nx;
   logic [NREQ-1:0]     gnt_nx;
   logic [IDW-1:0]      gnt_id_nx;
   logic                gnt_valid_nx;
   logic                preempt_nx;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
   logic [IDW-1:0]      last_ptr, last_ptr_nx;
   logic                sel_valid;
   logic [IDW-1:0]      sel_id;
   logic                limit_hit;

   rr_select8 u_sel (
      .req       (req),
      .base      (last_ptr),
      .mode      (mode),
      .sel_valid (sel_valid),
      .sel_id    (sel_id)
   );

   assign limit_hit = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);

   always_comb begin
      state_nx     = state;
      gnt_nx       = gnt;
      gnt_id_nx    = gnt_id;
      gnt_valid_nx = gnt_valid;
      preempt_nx   = 1'b0;
      hold_cnt_nx  = hold_cnt;
      last_ptr_nx  = last_ptr;
      case (state)
         ST_IDLE: begin
            gnt_nx       = '0;
            gnt_valid_nx = 1'b0;
            hold_cnt_nx  = '0;
            if (en && sel_valid) begin
               state_nx     = ST_GRANT;
               gnt_nx       = NREQ'(1) << sel_id;
               gnt_id_nx    = sel_id;
               gnt_valid_nx = 1'b1;
               last_ptr_nx  = sel_id;
            end
         end
         ST_GRANT: begin
            // abort and normal release take precedence over the hold limit
            if (!en || done || !req[gnt_id]) begin
               state_nx     = ST_IDLE;
               gnt_nx       = '0;
               gnt_valid_nx = 1'b0;
            end else if (limit_hit) begin
               state_nx     = ST_IDLE;
               gnt_nx       = '0;
               gnt_valid_nx = 1'b0;
               preempt_nx   = 1'b1;
            end else if (hold_cnt != '1) begin
               hold_cnt_nx = hold_cnt + 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         preempt   <= 1'b0;
         hold_cnt  <= '0;
         last_ptr  <= '0;
      end else begin
         state     <= state_nx;
         gnt       <= gnt_nx;
         gnt_id    <= gnt_id_nx;
         gnt_valid <= gnt_valid_nx;
         preempt   <= preempt_nx;
         hold_cnt  <= hold_cnt_nx;
         last_ptr  <= last_ptr_nx;
      end
   end

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed bench for req_arbiter8 with a cycle-level behavioural model and
// hand-computed literal checkpoints.
module tb_req_arbiter8;

   localparam int HOLD_MAX = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       preempt;

   int n_vec  = 0;
   int n_fail = 0;

   req_arbiter8 #(.HOLD_MAX(HOLD_MAX), .HOLD_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   // model: owner (-1 = nobody), cycles granted so far, last winner
   int   m_owner = -1;
   int   m_hold  = 0;
   int   m_last  = 0;
   int   m_id    = 0;
   bit   m_pre   = 1'b0;
   int   m_w;

   function automatic int pick(logic [7:0] r, logic rr, int last);
      if (!rr) begin
         for (int i = 7; i >= 0; i--) if (r[i]) return i;
      end else begin
         for (int i = 1; i <= 8; i++) begin
            int idx;
            idx = (last + 8 - i) % 8;
            if (r[idx]) return idx;
         end
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = -1; m_hold = 0; m_last = 0; m_id = 0; m_pre = 1'b0;
      end else if (m_owner < 0) begin
         m_pre = 1'b0;
         if (en && req != 8'h00) begin
            m_w     = pick(req, mode, m_last);
            m_owner = m_w;
            m_id    = m_w;
            m_last  = m_w;
            m_hold  = 1;
         end
      end else begin
         if (!en || done || !req[m_owner]) begin
            m_owner = -1;
            m_pre   = 1'b0;
         end else if (HOLD_MAX != 0 && m_hold == HOLD_MAX) begin
            m_owner = -1;
            m_pre   = 1'b1;
         end else begin
            m_hold++;
         end
      end
   end

   logic [7:0] exp_gnt;
   logic       exp_valid;

   always @(negedge clk) begin
      exp_gnt   = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      exp_valid = (m_owner >= 0);
      n_vec++;
      if (gnt !== exp_gnt || gnt_valid !== exp_valid ||
          gnt_id !== 3'(m_id) || preempt !== m_pre) begin
         n_fail++;
         $display("FAIL model t=%0t: got gnt=%b id=%0d valid=%b pre=%b, want gnt=%b id=%0d valid=%b pre=%b",
                  $time, gnt, gnt_id, gnt_valid, preempt, exp_gnt, m_id, exp_valid, m_pre);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #2 rst = 1'b1;
      #10 rst = 1'b0;
      tick(1);
      chk("reset_gnt", 32'(gnt), 32'h0);
      chk("reset_valid", 32'(gnt_valid), 32'h0);
      chk("reset_id", 32'(gnt_id), 32'h0);
      chk("reset_pre", 32'(preempt), 32'h0);

      // fixed priority
      en = 1'b1; mode = 1'b0; req = 8'b0010_0110;
      tick(1);
      chk("fix_gnt", 32'(gnt), 32'h20);
      chk("fix_id", 32'(gnt_id), 32'd5);
      chk("fix_valid", 32'(gnt_valid), 32'h1);
      done = 1'b1; req = 8'b0000_0110;
      tick(1);
      chk("fix_turnaround", 32'(gnt), 32'h0);
      done = 1'b0;
      tick(1);
      chk("fix_second_id", 32'(gnt_id), 32'd2);
      req = 8'h00;
      tick(1);
      chk("fix_drop_pre", 32'(preempt), 32'h0);

      // round-robin sweep from last_ptr = 0
      do_reset();
      mode = 1'b1; req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick(1);
         chk($sformatf("rr_id_%0d", k), 32'(gnt_id), 32'((15 - k) % 8));
         done = 1'b1;
         tick(1);
         chk($sformatf("rr_gap_%0d", k), 32'(gnt), 32'h0);
         done = 1'b0;
      end

      // hold limit with preemption, next owner by round-robin
      req = 8'h00;
      tick(1);
      do_reset();
      req = 8'h09;
      tick(1);
      chk("hold_first", 32'(gnt), 32'h08);
      tick(14);
      chk("hold_last_cycle", 32'(gnt), 32'h08);
      tick(1);
      chk("hold_gnt_off", 32'(gnt), 32'h0);
      chk("hold_preempt", 32'(preempt), 32'h1);
      tick(1);
      chk("hold_next_owner", 32'(gnt), 32'h01);
      chk("hold_pre_pulse", 32'(preempt), 32'h0);
      req = 8'h00;
      tick(1);

      // done coinciding with limit
      req = 8'h08;
      tick(1);
      chk("done_lim_grant", 32'(gnt), 32'h08);
      tick(14);
      done = 1'b1;
      tick(1);
      chk("done_lim_gnt", 32'(gnt), 32'h0);
      chk("done_lim_pre", 32'(preempt), 32'h0);
      done = 1'b0; req = 8'h00;
      tick(1);

      // en low coinciding with limit
      req = 8'h08;
      tick(15);
      en = 1'b0;
      tick(1);
      chk("en_lim_gnt", 32'(gnt), 32'h0);
      chk("en_lim_pre", 32'(preempt), 32'h0);
      tick(3);
      chk("en_low_idle", 32'(gnt_valid), 32'h0);

      // plain abort mid-grant
      en = 1'b1;
      tick(3);
      en = 1'b0;
      tick(1);
      chk("abort_gnt", 32'(gnt), 32'h0);
      chk("abort_pre", 32'(preempt), 32'h0);
      tick(2);
      chk("abort_stays_idle", 32'(gnt), 32'h0);

      // asynchronous reset between edges
      en = 1'b1; mode = 1'b1; req = 8'hFF;
      tick(1);
      chk("pre_rst_id", 32'(gnt_id), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("async_gnt", 32'(gnt), 32'h0);
      chk("async_valid", 32'(gnt_valid), 32'h0);
      chk("async_id", 32'(gnt_id), 32'h0);
      rst = 1'b0;
      tick(1);
      chk("post_rst_id", 32'(gnt_id), 32'd7);

      // mode change during a grant applies at the next arbitration
      done = 1'b1;
      tick(1);
      done = 1'b0; req = 8'h04;
      tick(1);
      chk("mode_grant", 32'(gnt_id), 32'd2);
      mode = 1'b0; req = 8'b0010_0110;
      tick(1);
      chk("mode_hold", 32'(gnt), 32'h04);
      req = 8'b0010_0010;
      tick(1);
      chk("mode_drop_gnt", 32'(gnt), 32'h0);
      chk("mode_drop_pre", 32'(preempt), 32'h0);
      tick(1);
      chk("mode_fixed_id", 32'(gnt_id), 32'd5);

      req = 8'h00;
      tick(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
